// File: rtl/set_cmp_unit_iter.sv
// set_cmp_unit_iter
//   Multi-cycle set/compare unit. It compares two XLEN operands SLICE_W bits
//   per cycle, starting at the most significant slice, and stops at the first
//   slice that differs. Operations: SLT, SLTU, MIN, MINU, MAX, MAXU, SEQ, SNE.
//
// Ports
//   CLK        clock, rising edge
//   rst_n      asynchronous active-low reset
//   In_Valid   issue request (Rs1, Rs2, Op valid)
//   In_Ready   unit idle, can accept an operation
//   Rs1, Rs2   operands (captured on accept)
//   Op         000 SLT, 001 SLTU, 010 MIN, 011 MINU,
//              100 MAX, 101 MAXU, 110 SEQ, 111 SNE
//   Out_Valid  Result valid (registered)
//   Out_Ready  consumer accepts Result
//   Result     registered result
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for In_Valid; In_Ready=1
// CMP   | scanning slice idx (first cycle also resolves signed sign mismatch)
// DONE  | Result held, Out_Valid=1 until Out_Ready

module set_cmp_unit_iter #(
  parameter int XLEN    = 32,
  parameter int SLICE_W = 8
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic            In_Valid,
  output logic            In_Ready,
  input  logic [XLEN-1:0] Rs1,
  input  logic [XLEN-1:0] Rs2,
  input  logic [2:0]      Op,
  output logic            Out_Valid,
  input  logic            Out_Ready,
  output logic [XLEN-1:0] Result
);

  localparam int NSLICE = XLEN / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic              lt_q, lt_d;
  logic              eq_q, eq_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              out_valid_q, out_valid_d;

  logic [SLICE_W-1:0] a_slice, b_slice;
  logic               is_signed;
  logic               finish;
  logic               lt_n, eq_n;
  logic [XLEN-1:0]    result_n;

  // SLT, MIN, MAX are signed; SEQ/SNE (op[2:1]==11) never are.
  assign is_signed = (op_q[2:1] != 2'b11) && !op_q[0];

  assign a_slice = a_q[idx_q*SLICE_W +: SLICE_W];
  assign b_slice = b_q[idx_q*SLICE_W +: SLICE_W];

  always_comb begin
    finish = 1'b0;
    lt_n   = 1'b0;
    eq_n   = 1'b0;
    // A sign mismatch on a signed op decides the result in the first cycle.
    // With equal signs the plain unsigned scan is exact for two's complement.
    if ((idx_q == LAST_IDX) && is_signed && (a_q[XLEN-1] != b_q[XLEN-1])) begin
      finish = 1'b1;
      lt_n   = a_q[XLEN-1];
    end else if (a_slice != b_slice) begin
      finish = 1'b1;
      lt_n   = (a_slice < b_slice);
    end else if (idx_q == '0) begin
      finish = 1'b1;
      eq_n   = 1'b1;
    end
  end

  always_comb begin
    result_n = '0;
    case (op_q)
      3'b000, 3'b001: result_n = {{(XLEN-1){1'b0}}, lt_n};
      3'b010, 3'b011: result_n = lt_n ? a_q : b_q;
      3'b100, 3'b101: result_n = lt_n ? b_q : a_q;
      3'b110:         result_n = {{(XLEN-1){1'b0}}, eq_n};
      default:        result_n = {{(XLEN-1){1'b0}}, ~eq_n};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    lt_d     = lt_q;
    eq_d     = eq_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (In_Valid) begin
          a_d     = Rs1;
          b_d     = Rs2;
          op_d    = Op;
          idx_d   = LAST_IDX;
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        if (finish) begin
          lt_d     = lt_n;
          eq_d     = eq_n;
          result_d = result_n;
          state_d  = ST_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (Out_Ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign In_Ready  = (state_q == ST_IDLE);
  assign Out_Valid = out_valid_q;
  assign Result    = result_q;

endmodule

// File: tb/tb_set_cmp_unit_iter.sv
// Directed bench for set_cmp_unit_iter (XLEN=32, SLICE_W=8).
// Inputs are driven on the falling edge and outputs sampled there too.

module tb_set_cmp_unit_iter;

  logic        CLK;
  logic        rst_n;
  logic        In_Valid;
  logic        In_Ready;
  logic [31:0] Rs1;
  logic [31:0] Rs2;
  logic [2:0]  Op;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [31:0] Result;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [2:0] OP_SLT  = 3'b000;
  localparam logic [2:0] OP_SLTU = 3'b001;
  localparam logic [2:0] OP_MIN  = 3'b010;
  localparam logic [2:0] OP_MINU = 3'b011;
  localparam logic [2:0] OP_MAX  = 3'b100;
  localparam logic [2:0] OP_MAXU = 3'b101;
  localparam logic [2:0] OP_SEQ  = 3'b110;
  localparam logic [2:0] OP_SNE  = 3'b111;

  set_cmp_unit_iter #(.XLEN(32), .SLICE_W(8)) dut (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Rs1       (Rs1),
    .Rs2       (Rs2),
    .Op        (Op),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Result    (Result)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after the accept edge; counts CMP cycles until Out_Valid.
  task automatic wait_valid(input string tag, input int exp_lat);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    @(negedge CLK);
    chk({tag, "_busy_ready"}, {31'b0, In_Ready}, 32'd0);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
      if (Out_Valid) seen = 1'b1;
    end
    chk({tag, "_seen"}, {31'b0, seen}, 32'd1);
    chk({tag, "_lat"}, n, exp_lat);
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [31:0] exp_r, input int exp_lat, input string tag);
    @(negedge CLK);
    Rs1 = a; Rs2 = b; Op = op; In_Valid = 1'b1;
    chk({tag, "_in_ready"}, {31'b0, In_Ready}, 32'd1);
    @(posedge CLK);
    // Scramble the ports while busy: only the captured copies may matter.
    #1;
    In_Valid = 1'b0; Rs1 = ~a; Rs2 = ~b; Op = ~op;
    wait_valid(tag, exp_lat);
    chk({tag, "_result"}, Result, exp_r);
    @(posedge CLK);
    @(negedge CLK);
    chk({tag, "_ov_low"}, {31'b0, Out_Valid}, 32'd0);
    chk({tag, "_hold"}, Result, exp_r);
  endtask

  initial begin
    rst_n = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b1;
    Rs1 = '0; Rs2 = '0; Op = '0;
    #12;
    chk("rst_out_valid", {31'b0, Out_Valid}, 32'd0);
    chk("rst_result", Result, 32'd0);
    chk("rst_in_ready", {31'b0, In_Ready}, 32'd1);
    @(negedge CLK);
    rst_n = 1'b1;

    do_op(32'hFFFF_FFFF, 32'h0000_0001, OP_SLT,  32'h0000_0001, 1, "slt_sign");
    do_op(32'hFFFF_FFFF, 32'h0000_0001, OP_SLTU, 32'h0000_0000, 1, "sltu_top");
    do_op(32'h1234_5678, 32'h1234_5678, OP_SEQ,  32'h0000_0001, 4, "seq_eq");
    do_op(32'h1234_5678, 32'h1234_5678, OP_SNE,  32'h0000_0000, 4, "sne_eq");
    do_op(32'h0000_00FF, 32'h0000_0100, OP_MINU, 32'h0000_00FF, 3, "minu_s1");
    do_op(32'h8000_0000, 32'h7FFF_FFFF, OP_MAX,  32'h7FFF_FFFF, 1, "max_sign");
    do_op(32'h8000_0000, 32'h7FFF_FFFF, OP_MAXU, 32'h8000_0000, 1, "maxu_top");
    // Both negative: equal signs, decided at slice 0 (0xFB < 0xFD).
    do_op(32'hFFFF_FFFB, 32'hFFFF_FFFD, OP_MIN,  32'hFFFF_FFFB, 4, "min_neg");
    do_op(32'h7FFF_FFFF, 32'h8000_0000, OP_SLT,  32'h0000_0000, 1, "slt_pos_neg");
    do_op(32'h7FFF_FFFF, 32'h8000_0000, OP_SLTU, 32'h0000_0001, 1, "sltu_7f_80");
    do_op(32'h0055_0000, 32'h0033_0000, OP_MAXU, 32'h0055_0000, 2, "maxu_s2");
    do_op(32'h1234_5678, 32'h1234_5679, OP_SNE,  32'h0000_0001, 4, "sne_lsb");
    do_op(32'hABCD_EF01, 32'hABCD_EF01, OP_MAX,  32'hABCD_EF01, 4, "max_equal");

    // Backpressure with a queued request held on In_Valid.
    Out_Ready = 1'b0;
    @(negedge CLK);
    Rs1 = 32'd3; Rs2 = 32'd5; Op = OP_SLTU; In_Valid = 1'b1;
    @(posedge CLK);
    #1;
    Rs1 = 32'd7; Rs2 = 32'd7; Op = OP_SEQ;
    wait_valid("bp", 4);
    for (int i = 0; i < 5; i++) begin
      chk("bp_ov", {31'b0, Out_Valid}, 32'd1);
      chk("bp_result", Result, 32'd1);
      chk("bp_in_ready", {31'b0, In_Ready}, 32'd0);
      @(posedge CLK);
      @(negedge CLK);
    end
    Out_Ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("bp_idle_ready", {31'b0, In_Ready}, 32'd1);
    chk("bp_idle_ov", {31'b0, Out_Valid}, 32'd0);
    @(posedge CLK);
    #1;
    In_Valid = 1'b0;
    wait_valid("bp_next", 4);
    chk("bp_next_result", Result, 32'd1);
    @(posedge CLK);

    // Reset while the scan is at idx=2.
    @(negedge CLK);
    Rs1 = 32'hA5A5_A5A5; Rs2 = 32'hA5A5_A5A5; Op = OP_SEQ; In_Valid = 1'b1;
    @(posedge CLK);
    #1;
    In_Valid = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("rmid_busy", {31'b0, In_Ready}, 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rmid_ov", {31'b0, Out_Valid}, 32'd0);
    chk("rmid_result", Result, 32'd0);
    chk("rmid_ready", {31'b0, In_Ready}, 32'd1);
    @(negedge CLK);
    rst_n = 1'b1;
    // 2 vs 7: equal upper slices, first difference in slice 0 -> 4 CMP cycles.
    do_op(32'd2, 32'd7, OP_SLT, 32'h0000_0001, 4, "post_rst_slt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
